// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// master drives operands and start; slave (the adder) returns result and status.
interface serial_adder_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, a, b,
        input  res, carry, overflow, busy, done
    );

    modport slave (
        input  start, sub, a, b,
        output res, carry, overflow, busy, done
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract of two WIDTH-bit operands, LSB first, one bit per clock.
// Latency: start edge -> WIDTH RUN cycles -> one-cycle done pulse; results hold until next completion.
// Backpressure: none; start is only sampled in IDLE and ignored while RUN or DONE.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] res_q;
    logic             c;
    logic             carry_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt;
    logic             sum;
    logic             cout;
    logic             last;

    always_comb begin
        sum       = areg[0] ^ breg[0] ^ c;
        cout      = (areg[0] & breg[0]) | (areg[0] & c) | (breg[0] & c);
        last      = (cnt == CW'(WIDTH - 1));
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            areg    <= '0;
            breg    <= '0;
            sreg    <= '0;
            res_q   <= '0;
            c       <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
                        areg <= bus.a;
                        breg <= bus.sub ? ~bus.b : bus.b;
                        c    <= bus.sub;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    areg <= areg >> 1;
                    breg <= breg >> 1;
                    c    <= cout;
                    sreg <= {sum, sreg[WIDTH-1:1]};
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        res_q   <= {sum, sreg[WIDTH-1:1]};
                        carry_q <= cout;
                        ovf_q   <= c ^ cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.res      = res_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=4 vector table and corner sequences, WIDTH=8 random back-to-back run.
module tb_serial_adder;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(4)) if4 ();
    serial_adder_if #(.WIDTH(8)) if8 ();

    serial_adder #(.WIDTH(4)) u4 (.clk(clk), .reset(reset), .bus(if4));
    serial_adder #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(if8));

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic [3:0] res;
        logic       carry;
        logic       ovf;
    } vec_t;

    typedef struct {
        int res;
        bit carry;
        bit ovf;
    } exp_t;

    vec_t tbl [8];
    exp_t q4 [$];
    exp_t q8 [$];
    int   total = 0;
    int   bad = 0;
    int   issued4 = 0;
    int   dones4 = 0;
    int   issued8 = 0;
    int   dones8 = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input int w, input int a, input int b, input bit sub);
        exp_t m;
        int mask;
        int bb;
        int s;
        bit sa;
        bit sb;
        bit sr;
        mask    = (1 << w) - 1;
        bb      = sub ? ((~b) & mask) : b;
        s       = a + bb + (sub ? 1 : 0);
        m.res   = s & mask;
        m.carry = ((s >> w) & 1) != 0;
        sa      = ((a >> (w - 1)) & 1) != 0;
        sb      = ((b >> (w - 1)) & 1) != 0;
        sr      = ((m.res >> (w - 1)) & 1) != 0;
        m.ovf   = sub ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
        return m;
    endfunction

    // Scoreboards: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (if4.done === 1'b1) begin
            dones4++;
            if (q4.size() == 0) begin
                check("done4_unexpected", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                check("res4", if4.res, e.res);
                check("carry4", if4.carry, e.carry);
                check("ovf4", if4.overflow, e.ovf);
                check("busy4_at_done", if4.busy, 0);
            end
        end
        if (if8.done === 1'b1) begin
            dones8++;
            if (q8.size() == 0) begin
                check("done8_unexpected", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                check("res8", if8.res, e.res);
                check("carry8", if8.carry, e.carry);
                check("ovf8", if8.overflow, e.ovf);
            end
        end
    end

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sub,
                        input logic [3:0] eres, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        if4.a     = a;
        if4.b     = b;
        if4.sub   = sub;
        if4.start = 1'b1;
        e.res = eres; e.carry = ec; e.ovf = eo;
        q4.push_back(e);
        issued4++;
        @(posedge clk);
        #1 if4.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("busy4_run", if4.busy, 1);
            check("done4_run", if4.done, 0);
            @(posedge clk);
            #1;
        end
        check("done4_pulse", if4.done, 1);
        check("busy4_done", if4.busy, 0);
        // Operand churn while idle must not disturb held results.
        if4.a   = 4'($urandom);
        if4.b   = 4'($urandom);
        if4.sub = 1'($urandom);
        @(posedge clk);
        #1;
        check("done4_one_cycle", if4.done, 0);
        repeat (2) @(posedge clk);
        #1;
        check("res4_hold", if4.res, eres);
        check("carry4_hold", if4.carry, ec);
        check("ovf4_hold", if4.overflow, eo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total + 1, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        exp_t e;
        tbl[0] = '{4'd5,  4'd3, 1'b0, 4'd8,  1'b0, 1'b1};
        tbl[1] = '{4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0};
        tbl[2] = '{4'd3,  4'd5, 1'b1, 4'd14, 1'b0, 1'b0};
        tbl[3] = '{4'd8,  4'd1, 1'b1, 4'd7,  1'b1, 1'b1};
        tbl[4] = '{4'd7,  4'd1, 1'b0, 4'd8,  1'b0, 1'b1};
        tbl[5] = '{4'd0,  4'd0, 1'b1, 4'd0,  1'b1, 1'b0};
        tbl[6] = '{4'd6,  4'd6, 1'b0, 4'd12, 1'b0, 1'b1};
        tbl[7] = '{4'd2,  4'd3, 1'b1, 4'd15, 1'b0, 1'b0};

        reset = 1'b1;
        if4.start = 1'b0; if4.sub = 1'b0; if4.a = '0; if4.b = '0;
        if8.start = 1'b0; if8.sub = 1'b0; if8.a = '0; if8.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res4", if4.res, 0);
        check("rst_carry4", if4.carry, 0);
        check("rst_ovf4", if4.overflow, 0);
        check("rst_busy4", if4.busy, 0);
        check("rst_done4", if4.done, 0);
        check("rst_res8", if8.res, 0);
        check("rst_busy8", if8.busy, 0);
        check("rst_done8", if8.done, 0);
        reset = 1'b0;

        // Reset wins over start on the same edge.
        @(negedge clk);
        reset = 1'b1; if4.start = 1'b1; if4.a = 4'd9; if4.b = 4'd9;
        @(posedge clk);
        #1 reset = 1'b0; if4.start = 1'b0;
        check("rst_prio_busy4", if4.busy, 0);
        repeat (6) @(posedge clk);

        for (int i = 0; i < 8; i++)
            run4(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].res, tbl[i].carry, tbl[i].ovf);

        // start re-pulsed with new operands mid-run is ignored.
        @(negedge clk);
        if4.a = 4'd5; if4.b = 4'd3; if4.sub = 1'b0; if4.start = 1'b1;
        e.res = 8; e.carry = 1'b0; e.ovf = 1'b1;
        q4.push_back(e);
        issued4++;
        @(posedge clk);
        #1 if4.start = 1'b0;
        @(posedge clk);
        #1 if4.start = 1'b1; if4.a = 4'd15; if4.b = 4'd15; if4.sub = 1'b1;
        @(posedge clk);
        #1 if4.start = 1'b0; if4.a = 4'd0; if4.b = 4'd0;
        repeat (6) @(posedge clk);
        #1;
        check("repulse_res4", if4.res, 8);
        check("repulse_q4_empty", q4.size(), 0);

        // Reset mid-run aborts with no done pulse.
        @(negedge clk);
        if4.a = 4'd7; if4.b = 4'd7; if4.sub = 1'b0; if4.start = 1'b1;
        @(posedge clk);
        #1 if4.start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_busy4", if4.busy, 0);
        check("abort_done4", if4.done, 0);
        check("abort_res4", if4.res, 0);
        check("abort_carry4", if4.carry, 0);
        check("abort_ovf4", if4.overflow, 0);
        repeat (8) @(posedge clk);
        run4(4'd9, 4'd4, 1'b1, 4'd5, 1'b1, 1'b1);
        check("done4_count", dones4, issued4);

        // WIDTH=8 random operations at the minimum issue interval.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if8.a     = 8'($urandom);
            if8.b     = 8'($urandom);
            if8.sub   = 1'($urandom);
            if8.start = 1'b1;
            q8.push_back(model(8, int'(if8.a), int'(if8.b), if8.sub));
            issued8++;
            @(posedge clk);
            #1 if8.start = 1'b0;
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            repeat (9) @(posedge clk);
        end
        w = 0;
        while (q8.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("q8_drained", q8.size(), 0);
        check("done8_count", dones8, issued8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits; legal range WIDTH >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port sub  input  1  operation mode captured with start: 0 = a+b, 1 = a-b.
REQ-006 SHALL have port a  input  WIDTH  first operand, captured with start.
REQ-007 SHALL have port b  input  WIDTH  second operand, captured with start.
REQ-008 SHALL have port res  output  WIDTH  result of last completed operation, modulo 2^WIDTH.
REQ-009 SHALL have port carry  output  1  carry-out of MSB (add); not-borrow (sub).
REQ-010 SHALL have port overflow  output  1  two's-complement signed overflow of last operation.
REQ-011 SHALL have port busy  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse, high while in DONE.

Function
REQ-013 SHALL implement FSM with states IDLE, RUN, DONE.
REQ-014 IDLE with start=1 at an edge SHALL load a into operand shift register A, b (sub=0) or ~b (sub=1) into register B, carry flop with sub, bit counter with 0, then go to RUN.
REQ-015 IDLE with start=0 SHALL remain in IDLE; all outputs hold.
REQ-016 Each RUN edge SHALL process exactly one bit, LSB first: sum = A[0]^B[0]^c; c <= majority(A[0],B[0],c); A and B shift right; sum shifts into the MSB end of an internal result register.
REQ-017 RUN SHALL last exactly WIDTH edges; the edge processing bit WIDTH-1 SHALL move to DONE and update res, carry, overflow in the same edge.
REQ-018 overflow SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-019 Latency: start sampled at edge E0 -> done high in the cycle after edge E0+WIDTH; busy high in the cycles after edges E0..E0+WIDTH-1.
REQ-020 DONE SHALL last one cycle and return to IDLE unconditionally; start in DONE SHALL be ignored.
REQ-021 start during RUN SHALL be ignored; operands and mode SHALL not change mid-operation.
REQ-022 res, carry, overflow SHALL change only on entry to DONE or on reset; they SHALL hold values between operations.
REQ-023 Back-to-back operations SHALL require start in IDLE; minimum issue interval WIDTH+2 cycles.
REQ-024 Changes on a, b, sub outside the start-sampling edge SHALL not affect any output.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE and clear res, carry, overflow, busy, done, carry flop, counter to 0, regardless of state.
REQ-026 reset SHALL take priority over start at the same edge; start is not captured.
REQ-027 reset during RUN SHALL abort the operation; no done pulse SHALL be produced for it.

Verification
REQ-028 WIDTH=4, a=5, b=3, sub=0 -> res=8, carry=0, overflow=1, done pulse one cycle after the 4th RUN edge, busy low with done.
REQ-029 WIDTH=4, a=15, b=1, sub=0 -> res=0, carry=1, overflow=0.
REQ-030 WIDTH=4, a=3, b=5, sub=1 -> res=14, carry=0, overflow=0; then a=8, b=1, sub=1 -> res=7, carry=1, overflow=1.
REQ-031 WIDTH=4, start re-pulsed and a/b changed in 2nd RUN cycle -> ignored, result matches first operands, single done pulse.
REQ-032 reset asserted in 2nd RUN cycle -> next cycle busy=0, done=0, res=0, carry=0, overflow=0; no done follows; next start operates normally.
REQ-033 WIDTH=8, 1000 random a/b/sub operations issued back-to-back at minimum interval -> res, carry, overflow match a behavioural model every time; done count equals start count.
